// File: rtl/ras_ckpt_pkg.sv
// Shared types for the return address stack: entry, prediction and checkpoint
// layouts, sized from the default stack geometry.
package ras_ckpt_pkg;

  localparam int VADDR_W   = 32;
  localparam int RAS_DEPTH = 16;
  localparam int RAS_CNT_W = 2;
  localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
  // A zero-width counter is kept as one constant-zero bit so the structs stay legal
  localparam int RAS_CW    = (RAS_CNT_W > 0) ? RAS_CNT_W : 1;

  typedef logic [VADDR_W-1:0] virt_t;

  typedef struct packed {
    virt_t data;
    logic  valid;
  } ras_t;

  typedef struct packed {
    virt_t              data;
    logic [RAS_CW-1:0]  cnt;
  } ras_entry_t;

  typedef struct packed {
    logic [RAS_PTR_W-1:0] tos;
    logic [RAS_PTR_W:0]   occ;
    virt_t                data;
    logic [RAS_CW-1:0]    cnt;
  } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt_if.sv
// Fetch-side RAS port bundle: push/pop predictions, top-of-stack prediction,
// checkpoint export and mispredict recovery.
interface ras_ckpt_if import ras_ckpt_pkg::*; ();

  logic      flush;
  logic      push_req;
  virt_t     push_data;
  logic      pop_req;
  ras_t      ras_top;
  ras_ckpt_t ckpt_o;
  logic      recover_req;
  ras_ckpt_t recover_ckpt;

  modport master (
    output flush, push_req, push_data, pop_req, recover_req, recover_ckpt,
    input  ras_top, ckpt_o
  );

  modport slave (
    input  flush, push_req, push_data, pop_req, recover_req, recover_ckpt,
    output ras_top, ckpt_o
  );

endinterface

// File: rtl/ras_ckpt.sv
// Circular return address stack with per-entry recursion counters; exports a
// checkpoint every cycle and repairs itself from a returned checkpoint.
module ras_ckpt import ras_ckpt_pkg::*; #(
  parameter int DEPTH = RAS_DEPTH,
  parameter int CNT_W = RAS_CNT_W
) (
  input  logic       clk,
  input  logic       resetn,
  ras_ckpt_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CW    = RAS_CW;
  localparam bit MERGE_EN = (CNT_W > 0);
  localparam logic [CW-1:0]    CNT_MAX  = CW'((1 << CNT_W) - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  ras_entry_t        mem_r [DEPTH];
  ras_entry_t        mem_s [DEPTH];
  logic [PTR_W-1:0]  tos_r;
  logic [PTR_W-1:0]  tos_s;
  logic [OCC_W-1:0]  occ_r;
  logic [OCC_W-1:0]  occ_s;
  ras_entry_t        top_s;

  // Next-state: recover beats flush beats push/pop
  always_comb begin
    mem_s = mem_r;
    tos_s = tos_r;
    occ_s = occ_r;
    top_s = mem_r[tos_r];
    if (bus.recover_req) begin
      tos_s = bus.recover_ckpt.tos;
      occ_s = bus.recover_ckpt.occ;
      mem_s[bus.recover_ckpt.tos] = '{data: bus.recover_ckpt.data, cnt: bus.recover_ckpt.cnt};
    end else if (bus.flush) begin
      tos_s = '0;
      occ_s = '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_s[i].cnt = '0;
      end
    end else if (bus.push_req && bus.pop_req) begin
      mem_s[tos_r] = '{data: bus.push_data, cnt: '0};
      occ_s = (occ_r == '0) ? OCC_W'(1) : occ_r;
    end else if (bus.push_req) begin
      // A repeated call to the same return site bumps the counter instead of a slot
      if (MERGE_EN && (occ_r != '0) && (bus.push_data == top_s.data) && (top_s.cnt != CNT_MAX)) begin
        mem_s[tos_r].cnt = top_s.cnt + CW'(1);
      end else begin
        tos_s = tos_r + PTR_W'(1);
        mem_s[tos_s] = '{data: bus.push_data, cnt: '0};
        occ_s = (occ_r == OCC_FULL) ? occ_r : occ_r + OCC_W'(1);
      end
    end else if (bus.pop_req) begin
      if (occ_r == '0) begin
        occ_s = occ_r;
      end else if (top_s.cnt != '0) begin
        mem_s[tos_r].cnt = top_s.cnt - CW'(1);
      end else begin
        tos_s = tos_r - PTR_W'(1);
        occ_s = occ_r - OCC_W'(1);
      end
    end else begin
      occ_s = occ_r;
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tos_r <= '0;
      occ_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      tos_r <= tos_s;
      occ_r <= occ_s;
      mem_r <= mem_s;
    end
  end

  // Prediction and checkpoint straight from the current registers
  always_comb begin
    bus.ras_top = '{data: mem_r[tos_r].data, valid: (occ_r != '0)};
    bus.ckpt_o  = '{tos: tos_r, occ: occ_r, data: mem_r[tos_r].data, cnt: mem_r[tos_r].cnt};
  end

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed and randomized bench for ras_ckpt against a slot-array reference
// model built from the stack rules with plain integer arithmetic.
module tb_ras_ckpt;
  import ras_ckpt_pkg::*;

  localparam int D    = RAS_DEPTH;
  localparam int CMAX = (1 << RAS_CNT_W) - 1;

  logic clk;
  logic resetn;
  ras_ckpt_if bus ();

  ras_ckpt dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int          m_tos;
  int          m_occ;
  int unsigned m_data [D];
  int          m_cnt  [D];
  ras_ckpt_t   hist [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tos = 0;
    m_occ = 0;
    for (int i = 0; i < D; i++) begin
      m_data[i] = 0;
      m_cnt[i]  = 0;
    end
  endtask

  function automatic ras_ckpt_t model_ckpt();
    ras_ckpt_t c;
    c.tos  = RAS_PTR_W'(m_tos);
    c.occ  = (RAS_PTR_W+1)'(m_occ);
    c.data = virt_t'(m_data[m_tos]);
    c.cnt  = RAS_CW'(m_cnt[m_tos]);
    return c;
  endfunction

  function automatic ras_t model_top();
    ras_t t;
    t.data  = virt_t'(m_data[m_tos]);
    t.valid = (m_occ != 0);
    return t;
  endfunction

  task automatic model_step(input bit push, input virt_t pd, input bit pop,
                            input bit fl, input bit rec, input ras_ckpt_t ck);
    if (rec) begin
      m_tos = int'(ck.tos);
      m_occ = int'(ck.occ);
      m_data[m_tos] = ck.data;
      m_cnt[m_tos]  = int'(ck.cnt);
    end else if (fl) begin
      m_tos = 0;
      m_occ = 0;
      for (int i = 0; i < D; i++) m_cnt[i] = 0;
    end else if (push && pop) begin
      m_data[m_tos] = pd;
      m_cnt[m_tos]  = 0;
      if (m_occ < 1) m_occ = 1;
    end else if (push) begin
      if (m_occ != 0 && pd == m_data[m_tos] && m_cnt[m_tos] < CMAX) begin
        m_cnt[m_tos]++;
      end else begin
        m_tos = (m_tos + 1) % D;
        m_data[m_tos] = pd;
        m_cnt[m_tos]  = 0;
        if (m_occ < D) m_occ++;
      end
    end else if (pop && m_occ != 0) begin
      if (m_cnt[m_tos] != 0) m_cnt[m_tos]--;
      else begin
        m_tos = (m_tos + D - 1) % D;
        m_occ--;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_top"},  64'(bus.ras_top), 64'(model_top()));
    chk({tag, "_ckpt"}, 64'(bus.ckpt_o),  64'(model_ckpt()));
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge, check at the next falling edge
  task automatic cyc(input string tag, input bit push, input virt_t pd, input bit pop,
                     input bit fl, input bit rec, input ras_ckpt_t ck);
    bus.push_req = push; bus.push_data = pd; bus.pop_req = pop;
    bus.flush = fl; bus.recover_req = rec; bus.recover_ckpt = ck;
    @(posedge clk);
    hist.push_back(model_ckpt());
    if (hist.size() > 32) void'(hist.pop_front());
    model_step(push, pd, pop, fl, rec, ck);
    @(negedge clk);
    bus.push_req = 1'b0; bus.pop_req = 1'b0; bus.flush = 1'b0; bus.recover_req = 1'b0;
    check_model(tag);
  endtask

  task automatic push(input string tag, input virt_t d);
    cyc(tag, 1'b1, d, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic pop(input string tag);
    cyc(tag, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    ras_ckpt_t saved;
    int        base_tos;
    int        occ_before;
    clk = 1'b0;
    resetn = 1'b0;
    bus.flush = 1'b0; bus.push_req = 1'b0; bus.push_data = '0; bus.pop_req = 1'b0;
    bus.recover_req = 1'b0; bus.recover_ckpt = '0;
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    check_model("reset");

    // Asynchronous reset in the middle of a push
    push("pre_a", 32'h700);
    push("pre_b", 32'h704);
    bus.push_req = 1'b1; bus.push_data = 32'h708;
    #2 resetn = 1'b0;
    #1;
    chk("rst_async_top",  64'(bus.ras_top), 64'h0);
    chk("rst_async_ckpt", 64'(bus.ckpt_o),  64'h0);
    model_reset();
    @(negedge clk);
    check_model("rst_hold");
    bus.push_req = 1'b0;
    resetn = 1'b1;
    pop("rst_pop");

    // LIFO order
    push("lifo_p1", 32'h100); push("lifo_p2", 32'h200); push("lifo_p3", 32'h300);
    chk("lifo_top", 64'(bus.ras_top.data), 64'h300);
    pop("lifo_q1"); chk("lifo_after1", 64'(bus.ras_top), {31'h0, 32'h200, 1'b1});
    pop("lifo_q2"); chk("lifo_after2", 64'(bus.ras_top), {31'h0, 32'h100, 1'b1});
    pop("lifo_q3"); chk("lifo_empty",  64'(bus.ras_top.valid), 64'h0);

    // Recursion merging
    base_tos = m_tos;
    push("rec_p1", 32'h400); push("rec_p2", 32'h400); push("rec_p3", 32'h400);
    chk("rec_tos", 64'(bus.ckpt_o.tos), 64'((base_tos + 1) % D));
    chk("rec_cnt", 64'(bus.ckpt_o.cnt), 64'd2);
    pop("rec_q1"); chk("rec_after1", 64'(bus.ras_top), {31'h0, 32'h400, 1'b1});
    pop("rec_q2"); chk("rec_after2", 64'(bus.ras_top), {31'h0, 32'h400, 1'b1});
    pop("rec_q3"); chk("rec_empty",  64'(bus.ras_top.valid), 64'h0);

    // Overflow wraps over the oldest entries
    for (int i = 0; i < 18; i++) push("ovf_push", virt_t'(32'h1000 + 4 * i));
    chk("ovf_occ", 64'(bus.ckpt_o.occ), 64'd16);
    chk("ovf_top", 64'(bus.ras_top.data), 64'h1044);
    for (int k = 1; k <= 16; k++) begin
      pop("ovf_pop");
      if (k < 16) chk("ovf_seq", 64'(bus.ras_top), {31'h0, 32'(32'h1044 - 4 * k), 1'b1});
      else        chk("ovf_empty", 64'(bus.ras_top.valid), 64'h0);
    end
    pop("ovf_underflow");
    chk("ovf_occ0", 64'(bus.ckpt_o.occ), 64'd0);

    // Mispredict recovery
    push("rcv_a", 32'hA0); push("rcv_b", 32'hB0);
    saved = model_ckpt();
    chk("rcv_ckpt_data", 64'(bus.ckpt_o.data), 64'hB0);
    pop("rcv_pop"); push("rcv_c", 32'hC0); push("rcv_d", 32'hD0);
    cyc("rcv_restore", 1'b0, '0, 1'b0, 1'b0, 1'b1, saved);
    chk("rcv_top", 64'(bus.ras_top), {31'h0, 32'hB0, 1'b1});
    pop("rcv_pop2");
    chk("rcv_top2", 64'(bus.ras_top), {31'h0, 32'hA0, 1'b1});

    // Same-cycle combinations
    push("sim_p", 32'h500);
    occ_before = m_occ;
    cyc("sim_pushpop", 1'b1, 32'h600, 1'b1, 1'b0, 1'b0, '0);
    chk("sim_pp_top", 64'(bus.ras_top.data), 64'h600);
    chk("sim_pp_occ", 64'(bus.ckpt_o.occ), 64'(occ_before));
    saved = model_ckpt();
    cyc("sim_rec_push", 1'b1, 32'h900, 1'b0, 1'b0, 1'b1, saved);
    chk("sim_rp_top", 64'(bus.ras_top.data), 64'h600);
    cyc("sim_flush_pop", 1'b0, '0, 1'b1, 1'b1, 1'b0, '0);
    chk("sim_fl_top", 64'(bus.ras_top.valid), 64'h0);
    chk("sim_fl_occ", 64'(bus.ckpt_o.occ), 64'h0);

    // Random traffic, small address pool so merging and recovery both occur
    for (int n = 0; n < 400; n++) begin
      int    r;
      bit    pu, po, fl, rc;
      virt_t d;
      ras_ckpt_t ck;
      r  = int'($urandom_range(0, 99));
      pu = 1'($urandom_range(0, 1));
      po = 1'($urandom_range(0, 1));
      fl = (r < 3);
      rc = (r >= 3 && r < 9 && hist.size() > 0);
      ck = rc ? hist[$urandom_range(0, hist.size() - 1)] : '0;
      d  = virt_t'(32'h100 * $urandom_range(1, 4));
      cyc("rand", pu, d, po, fl, rc, ck);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
